// File: rtl/lu_rr_arbiter_pkg.sv
// ============================================================================
// Module   : lu_pkg
// Brief    : Shared LU op codes, width and arbiter FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lu_pkg;

    localparam int LU_WIDTH = 4;

    localparam logic [1:0] LU_OP_ONES  = 2'b00;
    localparam logic [1:0] LU_OP_OR    = 2'b01;
    localparam logic [1:0] LU_OP_ZEROS = 2'b10;
    localparam logic [1:0] LU_OP_AND   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lu_rr_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin pick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    assign gnt_valid_o = valid0_i | valid1_i;
    // On contention the requester that did not win last time goes next.
    assign gnt_id_o    = (valid0_i & valid1_i) ? ~last_grant_i : valid1_i;

endmodule

`default_nettype wire

// File: rtl/lu_rr_arbiter.sv
// ============================================================================
// Module   : lu_rr_arbiter
// Brief    : Round-robin sharing of one external 4-bit logic unit by two requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lu_rr_arbiter
    import lu_pkg::*;
#(
    parameter int WIDTH     = LU_WIDTH,
    parameter int OP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_x,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_x,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [1:0]       lu_op,
    input  logic [WIDTH-1:0] lu_x,
    output logic             busy,
    output logic             grant_id,
    output logic [7:0]       op_count
);

    localparam logic [3:0] c_LAST_CNT = 4'(OP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d;
    logic [WIDTH-1:0] lu_b_q, lu_b_d;
    logic [1:0]       lu_op_q, lu_op_d;
    logic [WIDTH-1:0] rsp_x_q, rsp_x_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       op_count_q, op_count_d;

    logic w_gnt_valid;
    logic w_gnt_id;
    logic w_rsp_ready;

    rr_arb2 u_rr_arb2 (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (w_gnt_valid),
        .gnt_id_o     (w_gnt_id)
    );

    assign w_rsp_ready = grant_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        lu_a_d       = lu_a_q;
        lu_b_d       = lu_b_q;
        lu_op_d      = lu_op_q;
        rsp_x_d      = rsp_x_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_count_d   = op_count_q;
        case (state_q)
            ST_IDLE: begin
                // Ready is only offered to the winner, so a grant is an accept.
                if (w_gnt_valid) begin
                    lu_a_d  = w_gnt_id ? req1_a  : req0_a;
                    lu_b_d  = w_gnt_id ? req1_b  : req0_b;
                    lu_op_d = w_gnt_id ? req1_op : req0_op;
                    grant_d = w_gnt_id;
                    cnt_d   = 4'd0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == c_LAST_CNT) begin
                    rsp_x_d = lu_x;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_ready) begin
                    last_grant_d = grant_q;
                    op_count_d   = op_count_q + 8'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lu_a_q       <= '0;
            lu_b_q       <= '0;
            lu_op_q      <= '0;
            rsp_x_q      <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            lu_a_q       <= lu_a_d;
            lu_b_q       <= lu_b_d;
            lu_op_q      <= lu_op_d;
            rsp_x_q      <= rsp_x_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req0_ready = (state_q == ST_IDLE) && w_gnt_valid && !w_gnt_id;
    assign req1_ready = (state_q == ST_IDLE) && w_gnt_valid &&  w_gnt_id;
    assign rsp0_valid = (state_q == ST_RESP) && !grant_q;
    assign rsp1_valid = (state_q == ST_RESP) &&  grant_q;
    assign rsp0_x     = rsp_x_q;
    assign rsp1_x     = rsp_x_q;
    assign lu_a       = lu_a_q;
    assign lu_b       = lu_b_q;
    assign lu_op      = lu_op_q;
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_q;
    assign op_count   = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_lu_rr_arbiter.sv
// ============================================================================
// Module   : tb_lu_rr_arbiter
// Brief    : Self-checking bench; two DUTs (OP_CYCLES 1 and 3) share stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lu_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;

    logic [1:0] d_req0_ready, d_req1_ready, d_rsp0_valid, d_rsp1_valid, d_busy, d_gid;
    logic [3:0] d_rsp0_x[2], d_rsp1_x[2], d_lu_a[2], d_lu_b[2], d_lu_x[2];
    logic [1:0] d_lu_op[2];
    logic [7:0] d_opc[2];

    logic sel;
    int   n_tests, n_fail;

    function automatic logic [3:0] lu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
        case (op)
            2'b00:   return 4'b1111;
            2'b01:   return a | b;
            2'b10:   return 4'b0000;
            default: return a & b;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lu_rr_arbiter #(.WIDTH(4), .OP_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(req0_valid), .req0_ready(d_req0_ready[g]),
            .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
            .rsp0_valid(d_rsp0_valid[g]), .rsp0_ready(rsp0_ready), .rsp0_x(d_rsp0_x[g]),
            .req1_valid(req1_valid), .req1_ready(d_req1_ready[g]),
            .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
            .rsp1_valid(d_rsp1_valid[g]), .rsp1_ready(rsp1_ready), .rsp1_x(d_rsp1_x[g]),
            .lu_a(d_lu_a[g]), .lu_b(d_lu_b[g]), .lu_op(d_lu_op[g]), .lu_x(d_lu_x[g]),
            .busy(d_busy[g]), .grant_id(d_gid[g]), .op_count(d_opc[g])
        );
        assign d_lu_x[g] = lu_f(d_lu_a[g], d_lu_b[g], d_lu_op[g]);
    end

    // Outputs of whichever DUT the current test targets.
    logic       m_rdy0, m_rdy1, m_v0, m_v1, m_busy, m_gid;
    logic [3:0] m_x0, m_x1, m_la, m_lb;
    logic [1:0] m_lop;
    logic [7:0] m_opc;
    assign m_rdy0 = d_req0_ready[sel];
    assign m_rdy1 = d_req1_ready[sel];
    assign m_v0   = d_rsp0_valid[sel];
    assign m_v1   = d_rsp1_valid[sel];
    assign m_busy = d_busy[sel];
    assign m_gid  = d_gid[sel];
    assign m_x0   = d_rsp0_x[sel];
    assign m_x1   = d_rsp1_x[sel];
    assign m_la   = d_lu_a[sel];
    assign m_lb   = d_lu_b[sel];
    assign m_lop  = d_lu_op[sel];
    assign m_opc  = d_opc[sel];

    function automatic int op_cycles_sel();
        return sel ? 3 : 1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no event expected event within bound (t=%0t)", name, $time);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Full transaction from a negedge; lat = negedges after accept until rsp valid.
    task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, output logic [3:0] x, output int lat,
                         output logic gid);
        int k;
        x = '0; lat = -1; gid = 1'b0;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        k = 0;
        while (!(id ? m_rdy1 : m_rdy0) && k < 50) begin @(negedge clk); #1; k++; end
        if (k >= 50) begin
            fail_timeout("op_accept");
            idle_inputs();
            return;
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        gid = m_gid;
        lat = 1;
        while (!(id ? m_v1 : m_v0) && lat < 40) begin @(negedge clk); lat++; end
        if (lat >= 40) begin
            fail_timeout("op_response");
            return;
        end
        x = id ? m_x1 : m_x0;
        if (id) rsp1_ready = 1; else rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    typedef struct {
        logic       id;
        logic [3:0] a, b;
        logic [1:0] op;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] x;
        int         lat;
        logic       gid;
        int         got[$];
        logic       seen;

        n_tests = 0; n_fail = 0; sel = 1'b0;
        vecs[0] = '{1'b0, 4'b1010, 4'b0110, 2'b01, 4'b1110};
        vecs[1] = '{1'b1, 4'b1100, 4'b1010, 2'b00, 4'b1111};
        vecs[2] = '{1'b1, 4'b1100, 4'b1010, 2'b10, 4'b0000};
        vecs[3] = '{1'b1, 4'b1100, 4'b1010, 2'b01, 4'b1110};
        vecs[4] = '{1'b1, 4'b1100, 4'b1010, 2'b11, 4'b1000};
        vecs[5] = '{1'b0, 4'b0011, 4'b0101, 2'b11, 4'b0001};

        do_reset();
        #1;
        check("rst_busy", m_busy, 0);
        check("rst_opc", m_opc, 0);
        check("rst_gid", m_gid, 0);
        check("rst_rsp_valid", {m_v1, m_v0}, 0);
        check("rst_rsp_x", {m_x1, m_x0}, 0);
        check("rst_lu", {m_lop, m_lb, m_la}, 0);
        check("rst_ready", {m_rdy1, m_rdy0}, 0);

        // Table vectors, OP_CYCLES = 1.
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, x, lat, gid);
            #1;
            check("vec_x", x, vecs[i].exp);
            check("vec_gid", gid, vecs[i].id);
            check("vec_lat", 8'(lat), 8'(op_cycles_sel() + 1));
            check("vec_busy_after", m_busy, 0);
            check("vec_opc", m_opc, 8'(i + 1));
        end

        // Contention after reset: grants 0,1,0 with per-requester results.
        do_reset();
        req0_valid = 1; req0_a = 4'b0011; req0_b = 4'b0101; req0_op = 2'b11;
        req1_valid = 1; req1_a = 4'b0011; req1_b = 4'b0101; req1_op = 2'b01;
        rsp0_ready = 1; rsp1_ready = 1;
        got.delete();
        for (int c = 0; c < 60 && got.size() < 3; c++) begin
            @(negedge clk); #1;
            if (m_v0) begin check("cont_x0", m_x0, 4'b0001); check("cont_gid", m_gid, 0); got.push_back(0); end
            if (m_v1) begin check("cont_x1", m_x1, 4'b0111); check("cont_gid", m_gid, 1); got.push_back(1); end
        end
        if (got.size() < 3) fail_timeout("cont_grants");
        else begin
            check("cont_grant0", 8'(got[0]), 0);
            check("cont_grant1", 8'(got[1]), 1);
            check("cont_grant2", 8'(got[2]), 0);
        end

        // Response backpressure, OP_CYCLES = 3.
        sel = 1'b1;
        do_reset();
        req0_valid = 1; req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 2'b11;
        req1_valid = 1; req1_a = 4'b0001; req1_b = 4'b0010; req1_op = 2'b01;
        #1;
        check("bp_first_rdy", {m_rdy1, m_rdy0}, 2'b01);
        @(negedge clk);
        req0_valid = 0;
        lat = 1;
        while (!m_v0 && lat < 40) begin @(negedge clk); lat++; end
        check("bp_lat", 8'(lat), 8'd4);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", {m_v1, m_v0}, 2'b01);
            check("bp_x", m_x0, 4'b1000);
            check("bp_ready", {m_rdy1, m_rdy0}, 0);
            @(negedge clk);
        end
        rsp0_ready = 1; req1_valid = 0;
        @(negedge clk); #1;
        check("bp_release_busy", m_busy, 0);
        check("bp_release_opc", m_opc, 1);
        rsp0_ready = 0;

        // Reset mid-DRIVE (last completion was req0).
        req1_valid = 1; req1_a = 4'b1111; req1_b = 4'b0000; req1_op = 2'b01;
        #1;
        check("mid_rdy1", m_rdy1, 1);
        @(negedge clk); #1;
        check("mid_busy", m_busy, 1);
        rst = 1; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("mid_busy0", m_busy, 0);
        check("mid_opc0", m_opc, 0);
        check("mid_gid0", m_gid, 0);
        check("mid_lu0", {m_lop, m_lb, m_la}, 0);
        check("mid_x0", {m_x1, m_x0}, 0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1; seen = seen | m_v0 | m_v1;
            @(negedge clk);
        end
        check("mid_no_rsp", seen, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        check("mid_next_grant", {m_rdy1, m_rdy0}, 2'b01);

        // Counter wrap, OP_CYCLES = 1.
        sel = 1'b0;
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            do_op(1'(i % 2), 4'($urandom), 4'($urandom), 2'($urandom), x, lat, gid);
            #1;
            if (i == 255) check("wrap_255", m_opc, 8'd255);
            if (i == 256) check("wrap_256", m_opc, 8'd0);
            if (i == 257) check("wrap_257", m_opc, 8'd1);
        end

        // Random traffic against a transaction-level model, both DUTs.
        for (int s = 0; s < 2; s++) begin
            logic       mi, mo, ml, w_any, w_id;
            logic [3:0] mr;
            int         mw;
            logic [7:0] mc;
            sel = 1'(s);
            do_reset();
            mi = 0; mo = 0; ml = 1; mr = 0; mw = 0; mc = 0;
            for (int c = 0; c < 300; c++) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req1_valid = ($urandom_range(0, 3) != 0);
                req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
                req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
                rsp0_ready = ($urandom_range(0, 2) != 0);
                rsp1_ready = ($urandom_range(0, 2) != 0);
                #1;
                w_any = req0_valid | req1_valid;
                w_id  = (req0_valid && req1_valid) ? !ml : req1_valid;
                check("rnd_rdy0", m_rdy0, !mi && w_any && !w_id);
                check("rnd_rdy1", m_rdy1, !mi && w_any && w_id);
                check("rnd_v0", m_v0, mi && mw == 0 && !mo);
                check("rnd_v1", m_v1, mi && mw == 0 && mo);
                check("rnd_busy", m_busy, mi);
                check("rnd_opc", m_opc, mc);
                if (mi && mw == 0) check("rnd_x", mo ? m_x1 : m_x0, mr);
                if (!mi) begin
                    if (w_any) begin
                        mi = 1; mo = w_id; mw = op_cycles_sel();
                        mr = w_id ? lu_f(req1_a, req1_b, req1_op) : lu_f(req0_a, req0_b, req0_op);
                    end
                end else if (mw > 0) begin
                    mw--;
                end else if (mo ? rsp1_ready : rsp0_ready) begin
                    mi = 0; ml = mo; mc = mc + 8'd1;
                end
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
